hamming_rx_assembler: RTL

Downstream stage of the Hamming(7,4) link. It sits after the decoder (`cc_decoder_ht`) and consumes each corrected 7-bit codeword `rx` with its `error_det` flag. It extracts the 4 data bits and pairs consecutive nibbles into bytes, low nibble first. Each byte is tagged with an error flag and buffered in a small FIFO behind a valid/ready output handshake.

---
 rtl/hamming_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/hamming_rx_assembler.sv | 103 ++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared types and nibble extraction for the Hamming(7,4) receive assembler
package hamming_pkg;

  localparam int NIB_POS [4] = '{2, 4, 5, 6};

  typedef enum logic {EMPTY, HALF} asm_state_t;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } fifo_entry_t;

  function automatic logic [3:0] extract_nib(input logic [6:0] cw);
    logic [3:0] nib;
    for (int i = 0; i < 4; i++) begin
      nib[i] = cw[3'(NIB_POS[i])];
    end
    return nib;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO; a push while full only lands when a pop frees a slot in the same cycle
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;
  assign rdata = mem_q[head_q];

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (do_push) begin
      mem_d[tail_q] = wdata;
      tail_d        = tail_q + PW'(1);
    end
    if (do_pop) begin
      head_d = head_q + PW'(1);
    end
    count_d = count_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hamming_rx_assembler.sv
// rtl/hamming_rx_assembler.sv - pairs decoded Hamming(7,4) nibbles into error-tagged bytes behind a valid/ready FIFO
module hamming_rx_assembler
  import hamming_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [6:0]                    rx,
  input  logic                          error_det,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic                          out_err,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_count
);

  asm_state_t       state_q, state_d;
  logic             rx_valid_q, rx_valid_d;
  logic [3:0]       low_q, low_d;
  logic             err_lo_q, err_lo_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic        accept, push, pop, full, empty, drop;
  logic [3:0]  nib;
  fifo_entry_t wr_entry, rd_entry;

  assign accept    = rx_valid && !rx_valid_q;
  assign nib       = extract_nib(rx);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = rd_entry.data;
  assign out_err   = rd_entry.err;
  assign overflow  = overflow_q;
  assign drop_count = drop_count_q;

  always_comb begin
    state_d      = state_q;
    low_d        = low_q;
    err_lo_d     = err_lo_q;
    rx_valid_d   = rx_valid;
    push         = 1'b0;
    wr_entry     = '{err: err_lo_q | error_det, data: {nib, low_q}};
    case (state_q)
      EMPTY: if (accept) begin
        low_d    = nib;
        err_lo_d = error_det;
        state_d  = HALF;
      end
      HALF: if (accept) begin
        push    = 1'b1;
        state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    // Only a full FIFO with no simultaneous pop loses the byte.
    drop         = push && full && !pop;
    overflow_d   = overflow_q | drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      rx_valid_q   <= 1'b0;
      low_q        <= '0;
      err_lo_q     <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rx_valid_q   <= rx_valid_d;
      low_q        <= low_d;
      err_lo_q     <= err_lo_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule
